syzygy_dac_out_stage: RTL and testbench
=======================================

Name: syzygy_dac_out_stage

Overview:
- Output stage directly downstream of the two DDS memory readers (I and Q channels).
- Takes two 12-bit offset-binary sample streams, one new sample per clk each, and applies a per-channel digital gain and a shared soft mute/unmute ramp.
- Saturates the result and drives registered offset-binary words to the AD9116 pin driver.
- The ramp avoids full-scale steps on the DAC outputs when the host enables or disables generation.

Parameters:
RAMP_STEP, 1, level increment/decrement per clk while ramping; legal range 1..256.
MIDSCALE, 12'h800, offset-binary code driven while muted and during reset.

Ports:
clk  input  1  sample clock, shared with the DDS memory readers
reset  input  1  synchronous, active-high
enable  input  1  1 = unmute (ramp up), 0 = mute (ramp down); level-sensitive
gain_i  input  8  I gain, unsigned, 0x80 = 1.0, 0xFF = 1.992
gain_q  input  8  Q gain, same format
data_i  input  12  I sample, offset binary, from DDS memory reader
data_q  input  12  Q sample, offset binary
dac_i  output  12  scaled I sample, offset binary, registered
dac_q  output  12  scaled Q sample, offset binary, registered
level  output  9  current ramp level, 0..256
muted  output  1  1 when state is MUTED and level = 0

Behaviour:
- Reset values: dac_i = dac_q = MIDSCALE, level = 0, muted = 1, state = MUTED, all pipeline registers cleared to signed zero.
- Reset mid-ramp or mid-run: same values on the next edge; no partial ramp is retained.
- Per-channel datapath: fixed 3-cycle latency from data_x/gain_x to dac_x.
  - S1: s = data with MSB inverted (signed 12-bit, -2048..2047); p1 = (s * gain) >>> 7, arithmetic shift (floor), 13-bit signed; register p1.
  - S2: p2 = (p1 * level_reg) >>> 8, where level_reg is the level value registered in the same cycle S1 is registered; register p2, 13-bit signed.
  - S3: saturate p2 to -2048..2047, invert MSB, register to dac_x.
- Level-to-output alignment: the level value that affects a sample is the one present when that sample enters S2.
- Arithmetic: full-precision intermediates, no wrap. The S1 product is 21-bit signed; the S2 product is 22-bit signed.
- Exactness rules:
  - level = 0 forces p2 = 0, so dac = 0x800 exactly.
  - level = 256 with gain = 0x80 is bit-exact pass-through.
- FSM, registered, 4 states:
  - MUTED: level = 0. If enable = 1, go to RAMP_UP.
  - RAMP_UP: each clk, level <= min(level + RAMP_STEP, 256). If level reaches 256, go to RUN. If enable = 0, go to RAMP_DOWN without changing level that cycle.
  - RUN: level = 256. If enable = 0, go to RAMP_DOWN.
  - RAMP_DOWN: each clk, level <= max(level - RAMP_STEP, 0). If level reaches 0, go to MUTED. If enable = 1, go to RAMP_UP without changing level that cycle.
- Ramp timing:
  - With RAMP_STEP = 1, a full ramp from 0 takes 256 clks after the state enters RAMP_UP.
  - enable sampled high in MUTED gives state = RAMP_UP at the next edge, and level = 1 one edge later.
- Clamping: the last step clamps; RAMP_STEP need not divide 256.
- muted asserts in the same cycle the state enters MUTED.
- Gain changes take effect on the sample in S1 with no synchronisation; the host is responsible for glitch-free updates.
- enable toggling every clk: the state alternates between RAMP_UP and RAMP_DOWN, and level holds constant. This is legal.

Decomposition:
- Package syzygy_dac_pkg:
  - state enum (MUTED, RAMP_UP, RUN, RAMP_DOWN)
  - MIDSCALE default constant
  - LEVEL_FULL = 9'd256
  - saturation bounds SAT_MAX = 2047 and SAT_MIN = -2048
- Sub-module syzygy_dac_chan_scale: the 3-stage single-channel pipeline (data, gain, level in; dac out), instantiated twice.
- Top level holds the FSM and level counter.

Test Plan:
- Reset then enable = 0 for 50 clks: dac_i = dac_q = 0x800, muted = 1, level = 0 throughout.
- enable = 1, RAMP_STEP = 1, data_i = 0xFFF, gain_i = 0x80: level reaches 256 exactly 257 clks after enable is sampled. dac_i rises monotonically and settles at 0xFFF 3 clks after level = 256.
- RUN, gain_i = 0x40, data_i = 0xC00 → dac_i = 0xA00. Gain 0xFF with data_i 0xFFF → 0xFFF (sat high). Gain 0xFF with data_i 0x000 → 0x000 (sat low). Check 3-clk latency on a single-cycle data step.
- Hold level at 128 by toggling enable (RAMP_UP/RAMP_DOWN alternation), data_i = 0xC00, gain 0x80 → dac_i = 0xA00.
- RAMP_STEP = 100: up-ramp level sequence 100, 200, 256, then RUN. Down-ramp 156, 56, 0, then MUTED with muted = 1.
- Assert reset at level = 77 during RAMP_UP: next edge gives level = 0, dac = 0x800, muted = 1. After release with enable = 1, the ramp restarts from 0.

Source files
------------

// File: rtl/syzygy_dac_pkg.sv
// Shared types and constants for the SYZYGY DAC output stage.
// Contents: ramp FSM state enum, datapath widths, midscale code,
// full-scale ramp level, saturation bounds and an offset-binary helper.
package syzygy_dac_pkg;

    localparam int unsigned DATA_W  = 12;
    localparam int unsigned GAIN_W  = 8;
    localparam int unsigned LEVEL_W = 9;
    localparam int unsigned P_W     = 13;

    localparam logic [DATA_W-1:0]      MIDSCALE_DEFAULT = 12'h800;
    localparam logic [LEVEL_W-1:0]     LEVEL_FULL       = 9'd256;
    localparam logic signed [P_W-1:0]  SAT_MAX          = 13'sd2047;
    localparam logic signed [P_W-1:0]  SAT_MIN          = -13'sd2048;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } dac_state_e;

    // Offset binary to two's complement: flip the MSB.
    function automatic logic signed [DATA_W-1:0] ob_to_s(input logic [DATA_W-1:0] x);
        return $signed({~x[DATA_W-1], x[DATA_W-2:0]});
    endfunction

endpackage

// File: rtl/syzygy_dac_out_stage_if.sv
// Host/sample-side bus of the DAC output stage.
// master: drives enable, gain_i/gain_q, data_i/data_q; observes dac_i/dac_q, level, muted.
// slave : the output stage itself (opposite directions).
interface syzygy_dac_out_stage_if;
    import syzygy_dac_pkg::*;

    logic                enable;
    logic [GAIN_W-1:0]   gain_i;
    logic [GAIN_W-1:0]   gain_q;
    logic [DATA_W-1:0]   data_i;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   dac_i;
    logic [DATA_W-1:0]   dac_q;
    logic [LEVEL_W-1:0]  level;
    logic                muted;

    modport master (
        output enable, gain_i, gain_q, data_i, data_q,
        input  dac_i, dac_q, level, muted
    );

    modport slave (
        input  enable, gain_i, gain_q, data_i, data_q,
        output dac_i, dac_q, level, muted
    );

endinterface

// File: rtl/syzygy_dac_chan_scale.sv
// Single-channel 3-stage scaling pipeline: gain, ramp level, saturate.
// Ports: clk, reset (sync, active-high), data (offset binary), gain (0x80 = 1.0),
//        level (0..256, ramp level), dac (offset binary, registered).
module syzygy_dac_chan_scale
    import syzygy_dac_pkg::*;
#(
    parameter logic [DATA_W-1:0] MIDSCALE = MIDSCALE_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   data,
    input  logic [GAIN_W-1:0]   gain,
    input  logic [LEVEL_W-1:0]  level,
    output logic [DATA_W-1:0]   dac
);

    localparam int unsigned PROD1_W = DATA_W + GAIN_W + 1;
    localparam int unsigned PROD2_W = P_W + LEVEL_W;

    logic signed [PROD1_W-1:0]  prod1_c;
    logic signed [P_W-1:0]      p1_c;
    logic signed [P_W-1:0]      p1_q;
    logic [LEVEL_W-1:0]         level_q;
    logic signed [PROD2_W-1:0]  prod2_c;
    logic signed [P_W-1:0]      p2_c;
    logic signed [P_W-1:0]      p2_q;
    logic [DATA_W-1:0]          sat_c;
    logic [DATA_W-1:0]          dac_c;

    // S1: signed sample times unsigned gain, floor-divide by 128.
    always_comb begin
        prod1_c = PROD1_W'(ob_to_s(data)) * PROD1_W'($signed({1'b0, gain}));
        p1_c    = P_W'(prod1_c >>> 7);
    end

    // S2: scale by the level captured alongside the sample in S1.
    always_comb begin
        prod2_c = PROD2_W'(p1_q) * PROD2_W'($signed({1'b0, level_q}));
        p2_c    = P_W'(prod2_c >>> 8);
    end

    // S3: clamp to the 12-bit signed range and return to offset binary.
    always_comb begin
        sat_c = p2_q[DATA_W-1:0];
        if (p2_q > SAT_MAX) begin
            sat_c = SAT_MAX[DATA_W-1:0];
        end else if (p2_q < SAT_MIN) begin
            sat_c = SAT_MIN[DATA_W-1:0];
        end
        dac_c = {~sat_c[DATA_W-1], sat_c[DATA_W-2:0]};
    end

    // Pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_q    <= '0;
            level_q <= '0;
            p2_q    <= '0;
            dac     <= MIDSCALE;
        end else begin
            p1_q    <= p1_c;
            level_q <= level;
            p2_q    <= p2_c;
            dac     <= dac_c;
        end
    end

endmodule

// File: rtl/syzygy_dac_out_stage.sv
// DAC output stage: per-channel gain plus shared soft mute/unmute ramp for
// the I/Q DDS streams feeding the AD9116 pin driver.
// Ports: clk, reset (sync, active-high), bus (slave modport): enable, gain_i,
//        gain_q, data_i, data_q in; dac_i, dac_q, level, muted out (registered).
module syzygy_dac_out_stage
    import syzygy_dac_pkg::*;
#(
    parameter int unsigned       RAMP_STEP = 1,
    parameter logic [DATA_W-1:0] MIDSCALE  = MIDSCALE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    syzygy_dac_out_stage_if.slave   bus
);

    localparam int unsigned      SUM_W = LEVEL_W + 1;
    localparam logic [SUM_W-1:0] STEP  = SUM_W'(RAMP_STEP);

    dac_state_e          state_q;
    dac_state_e          state_nxt;
    logic [LEVEL_W-1:0]  level_q;
    logic [LEVEL_W-1:0]  level_nxt;
    logic                muted_q;
    logic                muted_nxt;
    logic [SUM_W-1:0]    up_sum_c;
    logic [LEVEL_W-1:0]  level_up_c;
    logic [LEVEL_W-1:0]  level_dn_c;

    // Clamped next ramp levels; the last step may be partial.
    always_comb begin
        up_sum_c   = {1'b0, level_q} + STEP;
        level_up_c = (up_sum_c > {1'b0, LEVEL_FULL}) ? LEVEL_FULL : up_sum_c[LEVEL_W-1:0];
        level_dn_c = ({1'b0, level_q} > STEP) ? (level_q - STEP[LEVEL_W-1:0]) : '0;
    end

    // Ramp FSM next state; a direction reversal holds the level for that cycle.
    always_comb begin
        state_nxt = state_q;
        level_nxt = level_q;
        case (state_q)
            MUTED: begin
                level_nxt = '0;
                if (bus.enable) state_nxt = RAMP_UP;
            end
            RAMP_UP: begin
                if (!bus.enable) begin
                    state_nxt = RAMP_DOWN;
                end else begin
                    level_nxt = level_up_c;
                    if (level_up_c == LEVEL_FULL) state_nxt = RUN;
                end
            end
            RUN: begin
                level_nxt = LEVEL_FULL;
                if (!bus.enable) state_nxt = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (bus.enable) begin
                    state_nxt = RAMP_UP;
                end else begin
                    level_nxt = level_dn_c;
                    if (level_dn_c == '0) state_nxt = MUTED;
                end
            end
            default: begin
                state_nxt = MUTED;
                level_nxt = '0;
            end
        endcase
        muted_nxt = (state_nxt == MUTED) && (level_nxt == '0);
    end

    // FSM state, level and muted flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MUTED;
            level_q <= '0;
            muted_q <= 1'b1;
        end else begin
            state_q <= state_nxt;
            level_q <= level_nxt;
            muted_q <= muted_nxt;
        end
    end

    assign bus.level = level_q;
    assign bus.muted = muted_q;

    syzygy_dac_chan_scale #(.MIDSCALE(MIDSCALE)) u_chan_i (
        .clk   (clk),
        .reset (reset),
        .data  (bus.data_i),
        .gain  (bus.gain_i),
        .level (level_q),
        .dac   (bus.dac_i)
    );

    syzygy_dac_chan_scale #(.MIDSCALE(MIDSCALE)) u_chan_q (
        .clk   (clk),
        .reset (reset),
        .data  (bus.data_q),
        .gain  (bus.gain_q),
        .level (level_q),
        .dac   (bus.dac_q)
    );

endmodule

// File: tb/tb_syzygy_dac_out_stage.sv
// Self-checking bench for syzygy_dac_out_stage: one instance with RAMP_STEP = 1
// and one with RAMP_STEP = 100.
module tb_syzygy_dac_out_stage;
    import syzygy_dac_pkg::*;

    logic clk = 1'b0;
    logic reset1;
    logic reset100;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    syzygy_dac_out_stage_if u_if1 ();
    syzygy_dac_out_stage_if u_if100 ();

    syzygy_dac_out_stage #(.RAMP_STEP(1)) u_dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (u_if1)
    );

    syzygy_dac_out_stage #(.RAMP_STEP(100)) u_dut100 (
        .clk   (clk),
        .reset (reset100),
        .bus   (u_if100)
    );

    typedef struct {
        string       name;
        logic [7:0]  gain_i;
        logic [11:0] data_i;
        logic [11:0] exp_i;
        logic [7:0]  gain_q;
        logic [11:0] data_q;
        logic [11:0] exp_q;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference arithmetic: offset binary in, floor scaling, saturate, offset binary out.
    function automatic logic [11:0] model_dac(input logic [11:0] d, input logic [7:0] g, input int lvl);
        int s;
        int p1;
        int p2;
        s  = int'(d) - 2048;
        p1 = (s * int'(g)) >>> 7;
        p2 = (p1 * lvl) >>> 8;
        if (p2 > 2047)  p2 = 2047;
        if (p2 < -2048) p2 = -2048;
        return 12'(p2 + 2048);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int lm;
        int up_lvl [5]  = '{0, 100, 200, 256, 256};
        int dn_lvl [5]  = '{256, 156, 56, 0, 0};
        logic dn_mut [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        vecs[0] = '{"unity",   8'h80, 12'hFFF, 12'hFFF, 8'h80, 12'h000, 12'h000};
        vecs[1] = '{"half",    8'h40, 12'hC00, 12'hA00, 8'h40, 12'h000, 12'h400};
        vecs[2] = '{"sat_hi",  8'hFF, 12'hFFF, 12'hFFF, 8'hFF, 12'h000, 12'h000};
        vecs[3] = '{"sat_lo",  8'hFF, 12'h000, 12'h000, 8'hFF, 12'hFFF, 12'hFFF};
        vecs[4] = '{"floor",   8'h81, 12'h7FF, 12'h7FE, 8'h80, 12'h7FF, 12'h7FF};
        vecs[5] = '{"gain_ff", 8'hFF, 12'hA00, 12'hBFC, 8'h00, 12'h123, 12'h800};
        vecs[6] = '{"mid",     8'h80, 12'h800, 12'h800, 8'hFF, 12'h800, 12'h800};
        vecs[7] = '{"x1p5",    8'hC0, 12'hC00, 12'hE00, 8'hC0, 12'h400, 12'h200};

        reset1   = 1'b1;
        reset100 = 1'b1;
        u_if1.enable = 1'b0;
        u_if1.gain_i = 8'h80;
        u_if1.gain_q = 8'h80;
        u_if1.data_i = 12'hFFF;
        u_if1.data_q = 12'h000;
        u_if100.enable = 1'b0;
        u_if100.gain_i = 8'h80;
        u_if100.gain_q = 8'h80;
        u_if100.data_i = 12'h800;
        u_if100.data_q = 12'h800;
        tick(3);

        check("reset_level", u_if1.level, 9'd0);
        check("reset_muted", u_if1.muted, 1'b1);
        check("reset_dac_i", u_if1.dac_i, 12'h800);
        check("reset_dac_q", u_if1.dac_q, 12'h800);

        reset1   = 1'b0;
        reset100 = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick(1);
            check("idle_dac_i", u_if1.dac_i, 12'h800);
            check("idle_dac_q", u_if1.dac_q, 12'h800);
            check("idle_level", u_if1.level, 9'd0);
            check("idle_muted", u_if1.muted, 1'b1);
        end

        // Full ramp with step 1: dac after edge m reflects level after edge m-3.
        u_if1.enable = 1'b1;
        for (int m = 0; m < 260; m++) begin
            tick(1);
            check("ramp_level", u_if1.level, 32'((m < 256) ? m : 256));
            check("ramp_muted", u_if1.muted, 1'b0);
            lm = m - 3;
            if (lm < 0)   lm = 0;
            if (lm > 256) lm = 256;
            check("ramp_dac_i", u_if1.dac_i, model_dac(12'hFFF, 8'h80, lm));
            check("ramp_dac_q", u_if1.dac_q, model_dac(12'h000, 8'h80, lm));
            if (m == 258) check("ramp_pre_settle_i", u_if1.dac_i, 12'hFF7);
        end
        check("ramp_settle_i", u_if1.dac_i, 12'hFFF);
        check("ramp_settle_q", u_if1.dac_q, 12'h000);

        // Gain/data vectors at full level.
        for (int v = 0; v < 8; v++) begin
            u_if1.gain_i = vecs[v].gain_i;
            u_if1.data_i = vecs[v].data_i;
            u_if1.gain_q = vecs[v].gain_q;
            u_if1.data_q = vecs[v].data_q;
            tick(4);
            check({vecs[v].name, "_i"}, u_if1.dac_i, vecs[v].exp_i);
            check({vecs[v].name, "_q"}, u_if1.dac_q, vecs[v].exp_q);
            check({vecs[v].name, "_level"}, u_if1.level, 9'd256);
        end

        // Single-cycle data step appears exactly 3 clocks later.
        u_if1.gain_i = 8'h80;
        u_if1.gain_q = 8'h80;
        u_if1.data_i = 12'h800;
        u_if1.data_q = 12'h800;
        tick(4);
        check("lat_base", u_if1.dac_i, 12'h800);
        u_if1.data_i = 12'hC00;
        u_if1.data_q = 12'h400;
        tick(1);
        u_if1.data_i = 12'h800;
        u_if1.data_q = 12'h800;
        check("lat_c1", u_if1.dac_i, 12'h800);
        tick(1);
        check("lat_c2", u_if1.dac_i, 12'h800);
        tick(1);
        check("lat_c3_i", u_if1.dac_i, 12'hC00);
        check("lat_c3_q", u_if1.dac_q, 12'h400);
        tick(1);
        check("lat_c4", u_if1.dac_i, 12'h800);

        // Ramp down to 128, then hold it by toggling enable.
        u_if1.data_i = 12'hC00;
        u_if1.data_q = 12'h400;
        u_if1.enable = 1'b0;
        tick(1);
        check("down_first_level", u_if1.level, 9'd256);
        for (int k = 1; k <= 128; k++) begin
            tick(1);
            check("down_level", u_if1.level, 32'(256 - k));
        end
        for (int t = 0; t < 12; t++) begin
            u_if1.enable = (t % 2 == 0);
            tick(1);
            check("hold_level", u_if1.level, 9'd128);
        end
        check("hold_dac_i", u_if1.dac_i, 12'hA00);
        check("hold_dac_q", u_if1.dac_q, 12'h600);
        check("hold_muted", u_if1.muted, 1'b0);

        // Reset in the middle of an up-ramp.
        reset1 = 1'b1;
        tick(2);
        reset1 = 1'b0;
        u_if1.data_i = 12'hFFF;
        u_if1.data_q = 12'h000;
        u_if1.gain_i = 8'h80;
        u_if1.gain_q = 8'h80;
        u_if1.enable = 1'b1;
        for (int m = 0; m <= 77; m++) begin
            tick(1);
            check("rst_ramp_level", u_if1.level, 32'(m));
        end
        check("rst_pre_dac_i", u_if1.dac_i, 12'hA4F);
        check("rst_pre_dac_q", u_if1.dac_q, 12'h5B0);
        reset1 = 1'b1;
        tick(1);
        check("rst_mid_level", u_if1.level, 9'd0);
        check("rst_mid_dac_i", u_if1.dac_i, 12'h800);
        check("rst_mid_dac_q", u_if1.dac_q, 12'h800);
        check("rst_mid_muted", u_if1.muted, 1'b1);
        reset1 = 1'b0;
        tick(1);
        check("rst_restart_l0", u_if1.level, 9'd0);
        check("rst_restart_m0", u_if1.muted, 1'b0);
        tick(1);
        check("rst_restart_l1", u_if1.level, 9'd1);
        tick(1);
        check("rst_restart_l2", u_if1.level, 9'd2);

        // Step 100: clamped last step in both directions.
        check("s100_idle_level", u_if100.level, 9'd0);
        check("s100_idle_muted", u_if100.muted, 1'b1);
        u_if100.enable = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick(1);
            check("s100_up_level", u_if100.level, 32'(up_lvl[j]));
            check("s100_up_muted", u_if100.muted, 1'b0);
        end
        u_if100.enable = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick(1);
            check("s100_dn_level", u_if100.level, 32'(dn_lvl[j]));
            check("s100_dn_muted", u_if100.muted, dn_mut[j]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
